// File: rtl/demux1to4b4_reg_pkg.sv
// Shared types and constants for the registered 1-to-4 nibble demultiplexer
// and its scan counter.
package demux1to4b4_reg_pkg;

  localparam int W_DEF = 4;
  localparam int SLOT_W = 2;
  localparam logic [3:0] FRAME_FULL = 4'b1111;

  function automatic logic [3:0] onehot2to4(input logic [SLOT_W-1:0] idx);
    logic [3:0] r;
    case (idx)
      2'd0:    r = 4'b0001;
      2'd1:    r = 4'b0010;
      2'd2:    r = 4'b0100;
      2'd3:    r = 4'b1000;
      default: r = 4'b0000;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/demux1to4b4_reg_scan_slot_counter.sv
// Clock divider plus 2-bit slot counter; the slot advances each time the
// divider wraps. Also used by the matching mux-side scanner.
module scan_slot_counter
  import demux1to4b4_reg_pkg::*;
#(
  parameter int SCAN_DIV = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_i,
  input  logic              en_i,
  output logic [SLOT_W-1:0] slot_o,
  output logic [SLOT_W-1:0] slot_nxt_o
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

  logic [DIV_W-1:0]  div_q, div_d;
  logic [SLOT_W-1:0] slot_q, slot_d;

  always_comb begin
    div_d  = div_q;
    slot_d = slot_q;
    if (clr_i) begin
      div_d  = '0;
      slot_d = '0;
    end else if (en_i) begin
      if (div_q == DIV_LAST) begin
        div_d  = '0;
        slot_d = slot_q + 2'd1;
      end else begin
        div_d = div_q + DIV_W'(1);
      end
    end else begin
      div_d  = div_q;
      slot_d = slot_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q  <= '0;
      slot_q <= '0;
    end else begin
      div_q  <= div_d;
      slot_q <= slot_d;
    end
  end

  assign slot_o     = slot_q;
  assign slot_nxt_o = slot_d;

endmodule

// File: rtl/demux1to4b4_reg.sv
// Registered 1-to-4 demultiplexer: routes a time-multiplexed W-bit stream into
// four holding registers, selected manually or by an internal scan counter.
module demux1to4b4_reg
  import demux1to4b4_reg_pkg::*;
#(
  parameter int W        = W_DEF,
  parameter int SCAN_DIV = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              auto,
  input  logic [SLOT_W-1:0] S,
  input  logic [W-1:0]      I,
  input  logic              valid,
  output logic [W-1:0]      o0,
  output logic [W-1:0]      o1,
  output logic [W-1:0]      o2,
  output logic [W-1:0]      o3,
  output logic [SLOT_W-1:0] sel_cur,
  output logic [3:0]        filled,
  output logic              frame_done
);

  logic [3:0][W-1:0]  o_q, o_d;
  logic [SLOT_W-1:0]  sel_cur_q, sel_cur_d;
  logic [3:0]         filled_q, filled_d;
  logic               frame_done_q, frame_done_d;
  logic               auto_q;
  logic               mode_chg;
  logic [SLOT_W-1:0]  slot, slot_nxt, ch;
  logic [3:0]         filled_nxt;

  // A mode change restarts the frame and the scan, and swallows that cycle's write.
  assign mode_chg = auto ^ auto_q;
  assign ch       = auto ? slot : S;

  scan_slot_counter #(
    .SCAN_DIV(SCAN_DIV)
  ) u_scan (
    .clk       (clk),
    .rst       (rst),
    .clr_i     (mode_chg),
    .en_i      (auto),
    .slot_o    (slot),
    .slot_nxt_o(slot_nxt)
  );

  always_comb begin
    o_d          = o_q;
    filled_d     = filled_q;
    frame_done_d = 1'b0;
    filled_nxt   = filled_q | onehot2to4(ch);
    if (mode_chg) begin
      filled_d = 4'b0000;
    end else if (valid) begin
      o_d[ch] = I;
      if (filled_nxt == FRAME_FULL) begin
        filled_d     = 4'b0000;
        frame_done_d = 1'b1;
      end else begin
        filled_d = filled_nxt;
      end
    end else begin
      filled_d = filled_q;
    end
  end

  always_comb begin
    sel_cur_d = sel_cur_q;
    if (auto) begin
      sel_cur_d = slot_nxt;
    end else if (valid && !mode_chg) begin
      sel_cur_d = S;
    end else begin
      sel_cur_d = sel_cur_q;
    end
  end

  // auto_q tracks auto even through reset so leaving reset is never a mode change.
  always_ff @(posedge clk) begin
    if (rst) begin
      o_q          <= '0;
      sel_cur_q    <= '0;
      filled_q     <= 4'b0000;
      frame_done_q <= 1'b0;
      auto_q       <= auto;
    end else begin
      o_q          <= o_d;
      sel_cur_q    <= sel_cur_d;
      filled_q     <= filled_d;
      frame_done_q <= frame_done_d;
      auto_q       <= auto;
    end
  end

  assign o0         = o_q[0];
  assign o1         = o_q[1];
  assign o2         = o_q[2];
  assign o3         = o_q[3];
  assign sel_cur    = sel_cur_q;
  assign filled     = filled_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_demux1to4b4_reg.sv
// Self-checking bench for demux1to4b4_reg: vector table for reset/manual
// sequences, then generated auto-scan, mode-toggle and mid-scan reset cycles.
module tb_demux1to4b4_reg;

  typedef struct packed {
    logic [3:0] o0;
    logic [3:0] o1;
    logic [3:0] o2;
    logic [3:0] o3;
    logic [1:0] sel;
    logic [3:0] filled;
    logic       fd;
  } exp_t;

  typedef struct packed {
    logic       rst;
    logic       auto_m;
    logic       valid;
    logic [1:0] s;
    logic [3:0] i;
    exp_t       e;
  } vec_t;

  logic       clk;
  logic       rst;
  logic       auto;
  logic [1:0] S;
  logic [3:0] I;
  logic       valid;
  logic [3:0] o0, o1, o2, o3;
  logic [1:0] sel_cur;
  logic [3:0] filled;
  logic       frame_done;

  int n_cmp = 0;
  int n_err = 0;
  exp_t sbq[$];
  vec_t tbl[18];
  logic [3:0] eo[4];
  logic [3:0] ef;

  demux1to4b4_reg #(.W(4), .SCAN_DIV(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .auto      (auto),
    .S         (S),
    .I         (I),
    .valid     (valid),
    .o0        (o0),
    .o1        (o1),
    .o2        (o2),
    .o3        (o3),
    .sel_cur   (sel_cur),
    .filled    (filled),
    .frame_done(frame_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step(input logic r, input logic a, input logic v,
                      input logic [1:0] s, input logic [3:0] i, input exp_t e);
    exp_t x;
    rst = r; auto = a; valid = v; S = s; I = i;
    sbq.push_back(e);
    @(posedge clk);
    #1;
    x = sbq.pop_front();
    chk("o0", 32'(o0), 32'(x.o0));
    chk("o1", 32'(o1), 32'(x.o1));
    chk("o2", 32'(o2), 32'(x.o2));
    chk("o3", 32'(o3), 32'(x.o3));
    chk("sel_cur", 32'(sel_cur), 32'(x.sel));
    chk("filled", 32'(filled), 32'(x.filled));
    chk("frame_done", 32'(frame_done), 32'(x.fd));
  endtask

  // Auto scan with valid held high and I = slot+1; S is random noise.
  task automatic run_auto(input int n);
    exp_t e;
    int s;
    logic [3:0] nf;
    for (int k = 0; k < n; k++) begin
      s = (k / 4) % 4;
      eo[s] = 4'(s + 1);
      nf = ef | (4'b0001 << s);
      e.fd = (nf == 4'b1111);
      ef = e.fd ? 4'b0000 : nf;
      e.o0 = eo[0]; e.o1 = eo[1]; e.o2 = eo[2]; e.o3 = eo[3];
      e.sel = 2'(((k + 1) / 4) % 4);
      e.filled = ef;
      step(1'b0, 1'b1, 1'b1, 2'($urandom_range(0, 3)), 4'(s + 1), e);
    end
  endtask

  initial begin
    exp_t ez;
    rst = 1'b1; auto = 1'b0; valid = 1'b0; S = 2'd0; I = 4'h0;

    //           rst   auto  valid S     I       o0    o1    o2    o3    sel   filled    fd
    tbl[0]  = '{1'b1, 1'b0, 1'b1, 2'd0, 4'hF, '{4'h0, 4'h0, 4'h0, 4'h0, 2'd0, 4'b0000, 1'b0}};
    tbl[1]  = '{1'b1, 1'b0, 1'b1, 2'd1, 4'hF, '{4'h0, 4'h0, 4'h0, 4'h0, 2'd0, 4'b0000, 1'b0}};
    tbl[2]  = '{1'b1, 1'b0, 1'b1, 2'd2, 4'hF, '{4'h0, 4'h0, 4'h0, 4'h0, 2'd0, 4'b0000, 1'b0}};
    tbl[3]  = '{1'b0, 1'b0, 1'b0, 2'd3, 4'hF, '{4'h0, 4'h0, 4'h0, 4'h0, 2'd0, 4'b0000, 1'b0}};
    tbl[4]  = '{1'b0, 1'b0, 1'b1, 2'd0, 4'h1, '{4'h1, 4'h0, 4'h0, 4'h0, 2'd0, 4'b0001, 1'b0}};
    tbl[5]  = '{1'b0, 1'b0, 1'b1, 2'd1, 4'h2, '{4'h1, 4'h2, 4'h0, 4'h0, 2'd1, 4'b0011, 1'b0}};
    tbl[6]  = '{1'b0, 1'b0, 1'b1, 2'd2, 4'h4, '{4'h1, 4'h2, 4'h4, 4'h0, 2'd2, 4'b0111, 1'b0}};
    tbl[7]  = '{1'b0, 1'b0, 1'b1, 2'd3, 4'h8, '{4'h1, 4'h2, 4'h4, 4'h8, 2'd3, 4'b0000, 1'b1}};
    tbl[8]  = '{1'b0, 1'b0, 1'b0, 2'd0, 4'h0, '{4'h1, 4'h2, 4'h4, 4'h8, 2'd3, 4'b0000, 1'b0}};
    tbl[9]  = '{1'b0, 1'b0, 1'b1, 2'd1, 4'h3, '{4'h1, 4'h3, 4'h4, 4'h8, 2'd1, 4'b0010, 1'b0}};
    tbl[10] = '{1'b0, 1'b0, 1'b1, 2'd1, 4'h5, '{4'h1, 4'h5, 4'h4, 4'h8, 2'd1, 4'b0010, 1'b0}};
    tbl[11] = '{1'b0, 1'b0, 1'b1, 2'd0, 4'h6, '{4'h6, 4'h5, 4'h4, 4'h8, 2'd0, 4'b0011, 1'b0}};
    tbl[12] = '{1'b0, 1'b0, 1'b1, 2'd2, 4'h7, '{4'h6, 4'h5, 4'h7, 4'h8, 2'd2, 4'b0111, 1'b0}};
    tbl[13] = '{1'b0, 1'b0, 1'b1, 2'd3, 4'h9, '{4'h6, 4'h5, 4'h7, 4'h9, 2'd3, 4'b0000, 1'b1}};
    tbl[14] = '{1'b0, 1'b0, 1'b0, 2'd2, 4'hE, '{4'h6, 4'h5, 4'h7, 4'h9, 2'd3, 4'b0000, 1'b0}};
    tbl[15] = '{1'b0, 1'b0, 1'b1, 2'd0, 4'hA, '{4'hA, 4'h5, 4'h7, 4'h9, 2'd0, 4'b0001, 1'b0}};
    tbl[16] = '{1'b0, 1'b0, 1'b1, 2'd1, 4'hB, '{4'hA, 4'hB, 4'h7, 4'h9, 2'd1, 4'b0011, 1'b0}};
    // Switch to auto with valid high: write dropped, filled/slot cleared.
    tbl[17] = '{1'b0, 1'b1, 1'b1, 2'd2, 4'hC, '{4'hA, 4'hB, 4'h7, 4'h9, 2'd0, 4'b0000, 1'b0}};

    for (int n = 0; n < 18; n++) begin
      step(tbl[n].rst, tbl[n].auto_m, tbl[n].valid, tbl[n].s, tbl[n].i, tbl[n].e);
    end

    // Scan starts from slot 0 right after the toggle cycle.
    eo[0] = 4'hA; eo[1] = 4'hB; eo[2] = 4'h7; eo[3] = 4'h9;
    ef = 4'b0000;
    run_auto(42);

    // Reset during slot 2 (divider mid-count), then scan must restart at slot 0.
    ez = '{4'h0, 4'h0, 4'h0, 4'h0, 2'd0, 4'b0000, 1'b0};
    step(1'b1, 1'b1, 1'b1, 2'd3, 4'hF, ez);
    eo[0] = 4'h0; eo[1] = 4'h0; eo[2] = 4'h0; eo[3] = 4'h0;
    ef = 4'b0000;
    run_auto(20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
